// File: rtl/trace_ctrl_pkg.sv
// Shared types and helpers for the trace_ctrl playback block.
package trace_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [7:0] CHAR_HIGH = 8'h2D;

   // Index width for a trace of len steps, never narrower than one bit.
   function automatic int calc_tw(input int len);
      return (len > 2) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/trace_ctrl_tap.sv
// trace_tap: decodes one ASCII trace channel at step index t_i.
module trace_tap
   import trace_ctrl_pkg::*;
#(
   parameter int               LEN   = 32,
   parameter logic [8*LEN-1:0] TRACE = {LEN{8'h5F}}
) (
   input  logic [calc_tw(LEN)-1:0] t_i,
   input  logic                    enable_i,
   output logic                    bit_o
);

   localparam int TW = calc_tw(LEN);

   // Padded to a power of two so any index value selects a defined bit.
   logic [(2**TW)-1:0] hi;

   for (genvar i = 0; i < 2**TW; i++) begin : g_chr
      if (i < LEN) begin : g_used
         assign hi[i] = (TRACE[8*(LEN-1-i) +: 8] == CHAR_HIGH);
      end else begin : g_pad
         assign hi[i] = 1'b0;
      end
   end

   assign bit_o = enable_i & hi[t_i];

endmodule

// File: rtl/trace_ctrl.sv
// trace_ctrl: steps through four ASCII waveform traces under start/pause/step/stop.
// Optional looping playback with a wrap counter is enabled by TRACE_CTRL_LOOP_EN.
module trace_ctrl
   import trace_ctrl_pkg::*;
#(
   parameter int                     TRACE_LEN = 32,
   parameter logic [8*TRACE_LEN-1:0] TRACE_A   = {TRACE_LEN{8'h5F}},
   parameter logic [8*TRACE_LEN-1:0] TRACE_B   = {TRACE_LEN{8'h5F}},
   parameter logic [8*TRACE_LEN-1:0] TRACE_C   = {TRACE_LEN{8'h5F}},
   parameter logic [8*TRACE_LEN-1:0] TRACE_D   = {TRACE_LEN{8'h5F}}
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          pause,
   input  logic                          step,
   input  logic                          stop,
`ifdef TRACE_CTRL_LOOP_EN
   input  logic                          loop,
   output logic [7:0]                    loop_count,
`endif
   output logic                          A,
   output logic                          B,
   output logic                          C,
   output logic                          D,
   output logic [calc_tw(TRACE_LEN)-1:0] t,
   output logic                          busy,
   output logic                          done
);

   localparam int            TW     = calc_tw(TRACE_LEN);
   localparam logic [TW-1:0] T_LAST = TW'(TRACE_LEN - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] t_q, t_d;
   logic          last;
   logic          adv;
   logic          loop_req;
   logic          en;

   assign last = (t_q == T_LAST);

`ifdef TRACE_CTRL_LOOP_EN
   logic       wrap;
   logic [7:0] cnt_q, cnt_d;

   assign loop_req = loop;
   assign wrap     = adv & last & loop;

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == IDLE)
         cnt_d = 8'd0;
      else if (wrap && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end

   assign loop_count = cnt_q;
`else
   assign loop_req = 1'b0;
`endif

   // adv marks a request to move one step forward, from RUN or a PAUSE step;
   // what happens at the end of the trace is resolved once, below the case.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      adv     = 1'b0;
      case (state_q)
         IDLE: begin
            t_d = '0;
            if (start) state_d = RUN;
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (pause) begin
               state_d = PAUSE;
            end else begin
               adv = 1'b1;
            end
         end
         PAUSE: begin
            if (stop) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (start) begin
               state_d = RUN;
            end else if (step) begin
               adv = 1'b1;
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (start) begin
               state_d = RUN;
               t_d     = '0;
            end else begin
               t_d = T_LAST;
            end
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase

      if (adv) begin
         if (!last)         t_d     = t_q + TW'(1);
         else if (loop_req) t_d     = '0;
         else               state_d = DONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   assign en   = (state_q != IDLE);
   assign busy = (state_q == RUN) || (state_q == PAUSE);
   assign done = (state_q == DONE);
   assign t    = t_q;

   trace_tap #(.LEN(TRACE_LEN), .TRACE(TRACE_A)) u_tap_a (.t_i(t_q), .enable_i(en), .bit_o(A));
   trace_tap #(.LEN(TRACE_LEN), .TRACE(TRACE_B)) u_tap_b (.t_i(t_q), .enable_i(en), .bit_o(B));
   trace_tap #(.LEN(TRACE_LEN), .TRACE(TRACE_C)) u_tap_c (.t_i(t_q), .enable_i(en), .bit_o(C));
   trace_tap #(.LEN(TRACE_LEN), .TRACE(TRACE_D)) u_tap_d (.t_i(t_q), .enable_i(en), .bit_o(D));

endmodule

// File: tb/tb_trace_ctrl.sv
// Self-checking bench for trace_ctrl: directed scenarios plus randomized control vs a reference model.
module tb_trace_ctrl;

   localparam logic [255:0] TR_A = {"_-", {30{"_"}}};
   localparam logic [255:0] TR_B = {8{"--__"}};
   localparam logic [255:0] TR_C = {16{"-_"}};
   localparam logic [255:0] TR_D = {4{"---_____"}};

   logic       clock = 1'b0;
   logic       reset = 1'b1, start = 1'b0, pause = 1'b0, step = 1'b0, stop = 1'b0;
   logic       A, B, C, D, busy, done;
   logic [4:0] t;

   int n_tests = 0;
   int n_fail  = 0;
   int ms = 0;   // model mode: 0 idle, 1 playing, 2 frozen, 3 finished
   int mt = 0;   // model step index

`ifdef TRACE_CTRL_LOOP_EN
   logic       loop_m = 1'b0;
   logic [7:0] lc_m;
   logic       r4 = 1'b1, s4 = 1'b0, p4 = 1'b0, st4 = 1'b0, sp4 = 1'b0, l4 = 1'b0;
   logic       A4, B4, C4, D4, busy4, done4;
   logic [1:0] t4;
   logic [7:0] lc4;
`endif

   always #5 clock = ~clock;

   trace_ctrl #(
      .TRACE_LEN(32), .TRACE_A(TR_A), .TRACE_B(TR_B), .TRACE_C(TR_C), .TRACE_D(TR_D)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .pause(pause), .step(step), .stop(stop),
`ifdef TRACE_CTRL_LOOP_EN
      .loop(loop_m), .loop_count(lc_m),
`endif
      .A(A), .B(B), .C(C), .D(D), .t(t), .busy(busy), .done(done)
   );

`ifdef TRACE_CTRL_LOOP_EN
   trace_ctrl #(.TRACE_LEN(4)) dut4 (
      .clock(clock), .reset(r4), .start(s4), .pause(p4), .step(st4), .stop(sp4),
      .loop(l4), .loop_count(lc4),
      .A(A4), .B(B4), .C(C4), .D(D4), .t(t4), .busy(busy4), .done(done4)
   );
`endif

   function automatic logic chan(input logic [255:0] tr, input int idx);
      logic [7:0] c;
      c = tr[8*(31-idx) +: 8];
      return c == 8'h2D;
   endfunction

   function automatic logic [3:0] exp_ch();
      if (ms == 0) return 4'b0;
      return {chan(TR_A, mt), chan(TR_B, mt), chan(TR_C, mt), chan(TR_D, mt)};
   endfunction

   task automatic model_step(input logic r, s, p, st, sp);
      if (r) begin
         ms = 0; mt = 0;
      end else begin
         case (ms)
            0: begin mt = 0; if (s) ms = 1; end
            1: if (sp) begin ms = 0; mt = 0; end
               else if (p) ms = 2;
               else if (mt == 31) ms = 3;
               else mt = mt + 1;
            2: if (sp) begin ms = 0; mt = 0; end
               else if (s) ms = 1;
               else if (st) begin
                  if (mt < 31) mt = mt + 1;
                  else ms = 3;
               end
            default: if (sp) begin ms = 0; mt = 0; end
                     else if (s) begin ms = 1; mt = 0; end
         endcase
      end
   endtask

   task automatic tick(input logic r, s, p, st, sp);
      reset = r; start = s; pause = p; step = st; stop = sp;
      @(posedge clock);
      model_step(r, s, p, st, sp);
      #1;
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      n_tests++; if (t !== 5'd0) begin n_fail++; $display("FAIL reset_t: got %0d want 0", t); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_tests++; if ({A, B, C, D} !== 4'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0000", {A, B, C, D}); end
`ifdef TRACE_CTRL_LOOP_EN
      n_tests++; if (lc_m !== 8'd0) begin n_fail++; $display("FAIL reset_lc: got %0d want 0", lc_m); end
`endif
      tick(0, 0, 0, 0, 0);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy %b want 0", busy); end
   endtask

   task automatic test_playback();
      tick(0, 1, 0, 0, 0);
      n_tests++; if (t !== 5'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL first_run: t=%0d busy=%b want t=0 busy=1", t, busy); end
      n_tests++; if (A !== 1'b0) begin n_fail++; $display("FAIL a_at_0: got %b want 0", A); end
      for (int k = 1; k <= 31; k++) begin
         tick(0, 0, 0, 0, 0);
         n_tests++; if (t !== 5'(k)) begin n_fail++; $display("FAIL play_t: got %0d want %0d", t, k); end
         n_tests++; if (A !== (k == 1)) begin n_fail++; $display("FAIL play_a: t=%0d got %b want %b", k, A, (k == 1)); end
      end
      n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL last_run: done=%b busy=%b want 0/1", done, busy); end
      for (int k = 0; k < 6; k++) begin
         tick(0, 0, 0, 0, 0);
         n_tests++;
         if (done !== 1'b1 || busy !== 1'b0 || t !== 5'd31) begin
            n_fail++; $display("FAIL done_hold: cyc=%0d done=%b busy=%b t=%0d want 1/0/31", k, done, busy, t);
         end
      end
   endtask

   task automatic test_pause();
      tick(0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick(0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 1, 0, 0);
         n_tests++;
         if (t !== 5'd5 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL pause_hold: t=%0d busy=%b done=%b want 5/1/0", t, busy, done);
         end
      end
      tick(0, 1, 0, 0, 0);
      n_tests++; if (t !== 5'd5) begin n_fail++; $display("FAIL resume_t0: got %0d want 5", t); end
      tick(0, 0, 0, 0, 0);
      n_tests++; if (t !== 5'd6) begin n_fail++; $display("FAIL resume_t1: got %0d want 6", t); end
   endtask

   task automatic test_step();
      for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 0, 0);
      n_tests++; if (t !== 5'd10) begin n_fail++; $display("FAIL step_pause: got %0d want 10", t); end
      for (int i = 1; i <= 3; i++) begin
         tick(0, 0, 0, 1, 0);
         n_tests++; if (t !== 5'(10 + i)) begin n_fail++; $display("FAIL step_adv: got %0d want %0d", t, 10 + i); end
         tick(0, 0, 0, 0, 0);
         n_tests++;
         if (t !== 5'(10 + i) || busy !== 1'b1) begin
            n_fail++; $display("FAIL step_stay: t=%0d busy=%b want %0d/1", t, busy, 10 + i);
         end
      end
      tick(0, 1, 0, 1, 0);
      n_tests++; if (t !== 5'd13) begin n_fail++; $display("FAIL step_start: got %0d want 13", t); end
      tick(0, 0, 0, 0, 0);
      n_tests++; if (t !== 5'd14) begin n_fail++; $display("FAIL step_start_run: got %0d want 14", t); end
   endtask

   task automatic test_simul();
      tick(0, 0, 0, 0, 1);
      tick(0, 1, 0, 0, 0);
      for (int k = 0; k < 7; k++) tick(0, 0, 0, 0, 0);
      tick(0, 1, 1, 0, 1);
      n_tests++;
      if (t !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || {A, B, C, D} !== 4'b0) begin
         n_fail++; $display("FAIL stop_all: t=%0d busy=%b done=%b ch=%b want 0/0/0/0000", t, busy, done, {A, B, C, D});
      end
      tick(0, 1, 0, 0, 0);
      for (int k = 0; k < 32; k++) tick(0, 0, 0, 0, 0);
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL reach_done: got %b want 1", done); end
      tick(0, 1, 0, 0, 0);
      n_tests++;
      if (t !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin
         n_fail++; $display("FAIL restart: t=%0d busy=%b done=%b want 0/1/0", t, busy, done);
      end
      for (int k = 0; k < 20; k++) tick(0, 0, 0, 0, 0);
      n_tests++; if (t !== 5'd20) begin n_fail++; $display("FAIL run_to_20: got %0d want 20", t); end
      n_tests++; if ({A, B, C, D} !== exp_ch()) begin n_fail++; $display("FAIL ch_at_20: got %b want %b", {A, B, C, D}, exp_ch()); end
      tick(1, 1, 0, 0, 0);
      n_tests++;
      if (t !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || {A, B, C, D} !== 4'b0) begin
         n_fail++; $display("FAIL mid_reset: t=%0d busy=%b done=%b ch=%b want 0/0/0/0000", t, busy, done, {A, B, C, D});
      end
   endtask

   task automatic test_random();
      logic r, s, p, st, sp;
      for (int k = 0; k < 3000; k++) begin
         r  = ($urandom_range(63) == 0);
         s  = ($urandom_range(5) == 0);
         p  = ($urandom_range(5) == 0);
         st = ($urandom_range(2) == 0);
         sp = ($urandom_range(19) == 0);
         tick(r, s, p, st, sp);
         n_tests++; if (t !== 5'(mt)) begin n_fail++; $display("FAIL rnd_t: cyc=%0d got %0d want %0d", k, t, mt); end
         n_tests++; if (busy !== (ms == 1 || ms == 2)) begin n_fail++; $display("FAIL rnd_busy: cyc=%0d got %b want %b", k, busy, (ms == 1 || ms == 2)); end
         n_tests++; if (done !== (ms == 3)) begin n_fail++; $display("FAIL rnd_done: cyc=%0d got %b want %b", k, done, (ms == 3)); end
         n_tests++; if ({A, B, C, D} !== exp_ch()) begin n_fail++; $display("FAIL rnd_ch: cyc=%0d got %b want %b", k, {A, B, C, D}, exp_ch()); end
      end
      tick(1, 0, 0, 0, 0);
   endtask

`ifdef TRACE_CTRL_LOOP_EN
   task automatic tick4(input logic r, s, p, st, sp, l);
      r4 = r; s4 = s; p4 = p; st4 = st; sp4 = sp; l4 = l;
      @(posedge clock);
      #1;
   endtask

   task automatic test_loop();
      tick4(1, 0, 0, 0, 0, 0);
      tick4(1, 0, 0, 0, 0, 0);
      n_tests++;
      if (lc4 !== 8'd0 || {A4, B4, C4, D4} !== 4'b0 || busy4 !== 1'b0) begin
         n_fail++; $display("FAIL loop_reset: lc=%0d ch=%b busy=%b want 0/0000/0", lc4, {A4, B4, C4, D4}, busy4);
      end
      tick4(0, 1, 0, 0, 0, 1);
      n_tests++; if (t4 !== 2'd0) begin n_fail++; $display("FAIL loop_t1: got %0d want 0", t4); end
      for (int k = 2; k <= 12; k++) begin
         tick4(0, 0, 0, 0, 0, 1);
         n_tests++; if (t4 !== 2'((k - 1) % 4) || busy4 !== 1'b1) begin n_fail++; $display("FAIL loop_seq: cyc=%0d t=%0d want %0d", k, t4, (k - 1) % 4); end
      end
      n_tests++; if (lc4 !== 8'd2) begin n_fail++; $display("FAIL loop_count12: got %0d want 2", lc4); end
      tick4(0, 0, 0, 0, 0, 0);
      n_tests++;
      if (done4 !== 1'b1 || t4 !== 2'd3 || lc4 !== 8'd2) begin
         n_fail++; $display("FAIL loop_drop: done=%b t=%0d lc=%0d want 1/3/2", done4, t4, lc4);
      end
      tick4(0, 1, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) tick4(0, 0, 0, 0, 0, 1);
      tick4(0, 0, 1, 0, 0, 1);
      tick4(0, 0, 0, 1, 0, 1);
      n_tests++;
      if (t4 !== 2'd0 || lc4 !== 8'd3 || busy4 !== 1'b1) begin
         n_fail++; $display("FAIL loop_step_wrap: t=%0d lc=%0d busy=%b want 0/3/1", t4, lc4, busy4);
      end
      tick4(0, 0, 0, 0, 1, 1);
      n_tests++; if (lc4 !== 8'd0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL loop_idle_clr: lc=%0d busy=%b want 0/0", lc4, busy4); end
      tick4(0, 1, 0, 0, 0, 1);
      for (int k = 0; k < 1200 && lc4 != 8'd255; k++) tick4(0, 0, 0, 0, 0, 1);
      n_tests++; if (lc4 !== 8'd255) begin n_fail++; $display("FAIL loop_reach_sat: got %0d want 255", lc4); end
      for (int k = 0; k < 5; k++) tick4(0, 0, 0, 0, 0, 1);
      n_tests++;
      if (lc4 !== 8'd255 || busy4 !== 1'b1) begin
         n_fail++; $display("FAIL loop_sat: lc=%0d busy=%b want 255/1", lc4, busy4);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_playback();
      test_pause();
      test_step();
      test_simul();
      test_random();
`ifdef TRACE_CTRL_LOOP_EN
      test_loop();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trace_ctrl.md
TRACE_CTRL -- requirements
Module: trace_ctrl

Interface
REQ-001 Parameter TRACE_LEN, default 32: trace length in steps; legal range 2..256.
REQ-002 Parameters TRACE_A, TRACE_B, TRACE_C, TRACE_D, each [8*TRACE_LEN-1:0], default all "_": per-channel ASCII trace; char index 0 is the most significant byte; "-" means high, any other char means low.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level-sampled: begin, resume or restart playback.
REQ-006 pause  input  1  level-sampled: freeze the step index.
REQ-007 step  input  1  level-sampled: advance one index while paused.
REQ-008 stop  input  1  level-sampled: abort and return to idle.
REQ-009 A, B, C, D  output  1 each  channel values at the current index.
REQ-010 t  output  T_W  current step index, where T_W = max(1, $clog2(TRACE_LEN)).
REQ-011 busy  output  1  high in RUN or PAUSE.
REQ-012 done  output  1  high in DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, with one transition per clock.
REQ-014 IDLE: start -> RUN, t=0; otherwise remain in IDLE with t=0.
- Index 0 is presented during the first RUN cycle.
REQ-015 RUN, in priority order:
- stop -> IDLE, t<=0.
- pause -> PAUSE, t held.
- t==TRACE_LEN-1 -> DONE, t held.
- otherwise t<=t+1.
- start is ignored in RUN.
REQ-016 PAUSE, in priority order:
- stop -> IDLE, t<=0.
- start -> RUN, t held; the increment resumes on the next cycle.
- step with t<TRACE_LEN-1 -> t<=t+1, stay in PAUSE.
- step with t==TRACE_LEN-1 -> DONE.
- otherwise hold.
REQ-017 DONE, in priority order:
- stop -> IDLE, t<=0.
- start -> RUN, t<=0.
- otherwise hold t at TRACE_LEN-1.
REQ-018 Channel outputs SHALL be combinational from t and state: in IDLE all four are 0; in RUN, PAUSE and DONE each channel = (trace char at index t == "-").
REQ-019 t SHALL never exceed TRACE_LEN-1 and SHALL never wrap, except as defined in REQ-024.
REQ-020 busy and done SHALL be decoded from state; they are never both high.

Reset
REQ-021 reset SHALL override all other inputs in the same cycle.
REQ-022 On reset: state=IDLE, t=0, A=B=C=D=0, busy=0, done=0.
- Reset in the middle of playback behaves identically to reset from any other state.
- start must be reasserted after reset to begin playback.

Configuration
REQ-023 Macro TRACE_CTRL_LOOP_EN SHALL add input port loop (1 bit) and output port loop_count (8 bits).
REQ-024 With TRACE_CTRL_LOOP_EN defined, in RUN at t==TRACE_LEN-1 with loop=1 and no stop/pause:
- t<=0 and the FSM stays in RUN.
- loop_count increments, saturating at 255.
- loop_count clears on reset or on entry to IDLE.
- In PAUSE, step at t==TRACE_LEN-1 with loop=1 also wraps t to 0 and increments loop_count.
REQ-025 Without TRACE_CTRL_LOOP_EN: ports loop and loop_count are absent, and the end of the trace always enters DONE.

Structure
REQ-026 Package trace_ctrl_pkg SHALL hold:
- the state enum (IDLE, RUN, PAUSE, DONE);
- localparam CHAR_HIGH = 8'h2D ("-");
- a function computing T_W from TRACE_LEN.
REQ-027 Sub-module trace_tap SHALL decode one channel:
- parameters LEN and TRACE; inputs t and enable; output bit.
- trace_ctrl instantiates trace_tap four times.
REQ-028 Formal properties (SVA) SHALL be bound externally and never embedded in the RTL.

Verification
REQ-029 TRACE_LEN=32, TRACE_A="_-" followed by 30 "_":
- reset 2 cycles, then start pulse.
- Required: A=1 exactly in the cycle with t==1; t reaches 31; done=1 from the next cycle on; t stays 31 for 5 more cycles.
REQ-030 Pause at t=5 for 3 cycles, then start:
- t holds at 5 during pause, busy=1, done=0.
- Required: t==6 on the second cycle after start.
REQ-031 In PAUSE at t=10, pulse step 3 times one cycle apart:
- Required: t=11, 12, 13; FSM stays in PAUSE.
- Step with start asserted in the same cycle: FSM -> RUN, t unchanged in that cycle.
REQ-032 Simultaneous inputs:
- stop+start+pause in RUN at t=7 -> IDLE, t=0, A..D=0.
- start in DONE -> RUN with t=0.
- reset asserted at t=20 in RUN -> all outputs at their reset values next cycle.
REQ-033 With TRACE_CTRL_LOOP_EN, TRACE_LEN=4, loop=1 for 12 RUN cycles:
- Required: t sequence 0,1,2,3,0,1,... and loop_count=2 after the 12 cycles.
- Drop loop -> DONE at the next t==3.
- Separately: force loop_count=255 plus one more wrap -> loop_count stays 255.
